// File: rtl/tt_um_led_jellyant.sv
// LED pattern generator: prescaled tick drives a blink LED and a 6-bit
// rotate/bounce/count pattern; bit 0 is a free-running inverter.
module tt_um_led_jellyant #(
  parameter int unsigned PRESCALE_W = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_e;

  mode_e                 mode;
  logic [2:0]            speed;
  logic                  advance;
  logic                  tick;
  logic [PRESCALE_W-1:0] cnt;
  logic [PRESCALE_W-1:0] all_ones;
  logic [PRESCALE_W-1:0] terminal;
  logic                  blink;
  logic [5:0]            pat;
  logic [5:0]            pat_nxt;
  logic                  dir;
  logic                  dir_nxt;
  logic                  pat_onehot;
  logic                  unused_uio;

  assign mode     = mode_e'(ui_in[5:4]);
  assign speed    = ui_in[3:1];
  assign advance  = ena & ~ui_in[6];

  // All-ones shifted right by s is exactly 2^(W-s)-1.
  assign all_ones = '1;
  assign terminal = all_ones >> speed;

  // >= rather than == so a speed change that lowers T mid-count still fires.
  assign tick     = advance & (cnt >= terminal);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt   <= '0;
      blink <= 1'b0;
      pat   <= 6'b000001;
      dir   <= 1'b0;
    end else if (advance) begin
      if (tick) begin
        cnt   <= '0;
        blink <= ~blink;
        pat   <= pat_nxt;
        dir   <= dir_nxt;
      end else begin
        cnt   <= cnt + PRESCALE_W'(1);
      end
    end
  end

  assign pat_onehot = (pat != '0) && ((pat & (pat - 6'd1)) == '0);

  always_comb begin
    pat_nxt = pat;
    dir_nxt = dir;
    unique case (mode)
      MODE_OFF: begin
        pat_nxt = pat;
      end
      MODE_ROTATE: begin
        if (!pat_onehot) begin
          pat_nxt = 6'b000001;
          dir_nxt = 1'b0;
        end else begin
          pat_nxt = {pat[4:0], pat[5]};
        end
      end
      MODE_BOUNCE: begin
        if (!pat_onehot) begin
          pat_nxt = 6'b000001;
          dir_nxt = 1'b0;
        end else if (pat == 6'b100000) begin
          pat_nxt = 6'b010000;
          dir_nxt = 1'b1;
        end else if (pat == 6'b000001) begin
          pat_nxt = 6'b000010;
          dir_nxt = 1'b0;
        end else if (dir) begin
          pat_nxt = pat >> 1;
        end else begin
          pat_nxt = pat << 1;
        end
      end
      MODE_COUNT: begin
        pat_nxt = pat + 6'd1;
      end
    endcase
  end

  assign uo_out[0]   = ~ui_in[0];
  assign uo_out[1]   = blink;
  assign uo_out[7:2] = ((mode == MODE_OFF) ? 6'b000000 : pat) ^ {6{ui_in[7]}};

  assign uio_out     = '0;
  assign uio_oe      = '0;
  assign unused_uio  = ^uio_in;

endmodule

// File: tb/tb_tt_um_led_jellyant.sv
// Scoreboard bench for tt_um_led_jellyant (PRESCALE_W=8): a driver feeds
// directed and random stimulus through a reference model; a monitor compares.
module tb_tt_um_led_jellyant;

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;

  typedef struct {
    logic [7:0] uo;
  } exp_t;
  exp_t sb[$];

  // reference model state
  int m_cnt;
  int m_blink;
  int m_pat;
  int m_dir;
  int cur_mode;

  tt_um_led_jellyant #(.PRESCALE_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  function automatic bit is_onehot(input int v);
    int n;
    n = 0;
    for (int i = 0; i < 6; i++) if (((v >> i) & 1) == 1) n++;
    return n == 1;
  endfunction

  function automatic logic [7:0] model_out(input logic [7:0] u);
    int shown;
    shown = (u[5:4] == 2'b00) ? 0 : m_pat;
    if (u[7]) shown = 63 - shown;
    return {shown[5:0], m_blink[0], ~u[0]};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_blink = 0; m_pat = 1; m_dir = 0;
  endtask

  task automatic model_step(input logic [7:0] u);
    int t;
    t = (1 << (8 - int'(u[3:1]))) - 1;
    if (m_cnt < t) begin
      m_cnt++;
      return;
    end
    m_cnt = 0;
    m_blink = 1 - m_blink;
    case (u[5:4])
      2'b01: begin
        if (!is_onehot(m_pat)) begin m_pat = 1; m_dir = 0; end
        else m_pat = (m_pat * 2) % 64 + m_pat / 32;
      end
      2'b10: begin
        if (!is_onehot(m_pat)) begin m_pat = 1; m_dir = 0; end
        else if (m_pat == 32) begin m_pat = 16; m_dir = 1; end
        else if (m_pat == 1) begin m_pat = 2; m_dir = 0; end
        else if (m_dir == 1) m_pat = m_pat / 2;
        else m_pat = m_pat * 2;
      end
      2'b11: m_pat = (m_pat + 1) % 64;
      default: ;
    endcase
  endtask

  // Apply one cycle of inputs just after the falling edge.
  task automatic drive(input logic r, input logic e, input logic [7:0] u);
    exp_t x;
    @(negedge clk);
    rst_n  = r;
    ena    = e;
    ui_in  = u;
    uio_in = 8'($urandom);
    if (r) model_reset();
    x.uo = model_out(u);
    sb.push_back(x);
    if (!r && e && !u[6]) model_step(u);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // monitor: outputs settle between falling edge and next rising edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk("uo_out", uo_out, e.uo);
        chk("uio_out", uio_out, 8'h00);
        chk("uio_oe", uio_oe, 8'h00);
      end
    end
  end

  function automatic logic [7:0] mk(input int inv, input int pause, input int mode,
                                    input int s, input int b0);
    return {inv[0], pause[0], mode[1:0], s[2:0], b0[0]};
  endfunction

  initial begin
    logic [7:0] u;
    int mode_r;
    checks = 0; failures = 0;
    clk_run = 1'b0;
    rst_n = 1'b0; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;

    // clock stopped: async reset and combinational inverter
    #1 rst_n = 1'b1;
    ui_in = mk(0, 0, 1, 7, 0);
    #4 chk("inv_lo_rst", {7'd0, uo_out[0]}, 8'h01);
    chk("rst_rotate", uo_out[7:1], 7'b0000010);
    chk("rst_uio", uio_out | uio_oe, 8'h00);
    ui_in = mk(0, 0, 1, 7, 1);
    #4 chk("inv_hi_rst", {7'd0, uo_out[0]}, 8'h00);
    ui_in = mk(0, 0, 0, 7, 1);
    #4 chk("rst_off", {2'd0, uo_out[7:2]}, 8'h00);
    ui_in = mk(1, 0, 0, 7, 1);
    #4 chk("rst_off_inv", {2'd0, uo_out[7:2]}, 8'h3f);

    model_reset();
    clk_run = 1'b1;

    // rotate, T=1
    repeat (3) drive(1, 1, mk(0, 0, 1, 7, 0));
    for (int i = 0; i < 16; i++) drive(0, 1, mk(0, 0, 1, 7, i));
    // bounce, T=1
    repeat (2) drive(1, 1, mk(0, 0, 2, 7, 0));
    for (int i = 0; i < 28; i++) drive(0, 1, mk(0, 0, 2, 7, i));
    // count past wrap, then rotate from a non-one-hot value
    repeat (2) drive(1, 1, mk(0, 0, 3, 7, 0));
    for (int i = 0; i < 140; i++) drive(0, 1, mk(i % 2, 0, 3, 7, i));
    for (int i = 0; i < 8; i++) drive(0, 1, mk(0, 0, 1, 7, i));
    // pause, then disable, then resume
    for (int i = 0; i < 20; i++) drive(0, 1, mk(0, 1, 2, 7, i));
    for (int i = 0; i < 6; i++) drive(0, 1, mk(0, 0, 2, 7, i));
    for (int i = 0; i < 20; i++) drive(0, 0, mk(0, 0, 2, 7, i));
    for (int i = 0; i < 6; i++) drive(0, 1, mk(0, 0, 2, 7, i));
    // slow count in progress, then speed jumps to T=1
    for (int i = 0; i < 30; i++) drive(0, 1, mk(0, 0, 1, 0, i));
    for (int i = 0; i < 6; i++) drive(0, 1, mk(0, 0, 1, 7, i));
    // reset mid-sequence, then let a slower terminal count complete
    drive(1, 1, mk(0, 0, 1, 6, 0));
    for (int i = 0; i < 20; i++) drive(0, 1, mk(0, 0, 1, 6, i));

    // random phase
    mode_r = 1;
    for (int i = 0; i < 3000; i++) begin
      u = 8'($urandom);
      if ($urandom_range(0, 39) == 0) mode_r = $urandom_range(0, 3);
      u[5:4] = 2'(mode_r);
      if ($urandom_range(0, 3) != 0) u[3:1] = 3'($urandom_range(5, 7));
      u[6] = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), u);
    end

    @(negedge clk);
    #4;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tt_um_led_jellyant.md
TT_UM_LED_JELLYANT -- requirements
Module: tt_um_led_jellyant

Interface
REQ-001 Parameter: PRESCALE_W, default 24, prescaler counter width; legal range 8..32.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 rst_n  in  1  reset; name follows the codebase port convention; asserted HIGH (1 = reset), asynchronous assert.
REQ-005 ena  in  1  enable; 1 = registers advance, 0 = all registers hold.
REQ-006 ui_in  in  8  [0] inverter input, [3:1] speed s, [5:4] mode, [6] pause, [7] pattern invert.
REQ-007 uio_in  in  8  unused; ignored.
REQ-008 uo_out  out  8  [0] inverter output, [1] blink LED, [7:2] 6-bit LED pattern.
REQ-009 uio_out  out  8  tied to 8'h00.
REQ-010 uio_oe  out  8  tied to 8'h00 (all uio pins are inputs).

Function
REQ-011 uo_out[0] SHALL equal NOT ui_in[0], purely combinational, independent of clk, reset and ena.
REQ-012 Prescaler: PRESCALE_W-bit up-counter; terminal T = 2^(PRESCALE_W - s) - 1, with s = ui_in[3:1].
REQ-013 Tick SHALL be asserted for one cycle when counter >= T (covers a speed change lowering T mid-count); counter returns to 0 on the same edge, otherwise increments.
REQ-014 Prescaler SHALL advance only when ena=1 and ui_in[6]=0; when paused it holds its value.
REQ-015 Blink register SHALL toggle on every tick; uo_out[1] = blink register.
REQ-016 Pattern register P[5:0] and direction bit D (0 = left/up, 1 = right/down) SHALL update only on a tick.
REQ-017 Mode 00 (off): P and D hold; uo_out[7:2] = 6'b000000 before inversion.
REQ-018 Mode 01 (rotate): P rotates left by one; 100000 -> 000001.
REQ-019 Mode 10 (bounce): shift in direction D; when P = 100000, D becomes 1 and P becomes 010000; when P = 000001, D becomes 0 and P becomes 000010.
REQ-020 Mode 11 (count): P increments modulo 64 (63 -> 0); D unchanged.
REQ-021 In modes 01/10, a P that is not one-hot (e.g. after count mode) SHALL be reloaded to 000001 with D=0 on the next tick instead of shifting.
REQ-022 Mode changes take effect on the next tick; no reset of P occurs on a mode change except per REQ-021.
REQ-023 uo_out[7:2] = (mode==00 ? 0 : P) XOR {6{ui_in[7]}}, combinational from registers and inputs.
REQ-024 All outputs except uo_out[0] and uo_out[7:2] inversion path are registered; no combinational path from ui_in[3:1] or ui_in[6] to any output.

Reset
REQ-025 While rst_n=1: prescaler = 0, blink = 0, P = 000001, D = 0, no tick issued.
REQ-026 Reset SHALL take effect immediately, without a clock edge; on release the first tick occurs T+1 enabled cycles later.
REQ-027 Reset mid-sequence SHALL discard the pattern and any partial prescale count.

Verification
REQ-028 ui_in[0]=0 -> uo_out[0]=1 within 5 ns; ui_in[0]=1 -> uo_out[0]=0 within 5 ns; holds with rst_n=1 and clk stopped.
REQ-029 Reset asserted, mode 01, ui_in[7]=0 -> uo_out[1]=0, uo_out[7:2]=000001, uio_out=00, uio_oe=00; mode 00 -> uo_out[7:2]=000000, ui_in[7]=1 -> 111111.
REQ-030 PRESCALE_W=8, s=7 (T=1), mode 01: tick every 2 cycles; uo_out[7:2] runs 1,2,4,8,16,32,1; uo_out[1] toggles each tick.
REQ-031 PRESCALE_W=8, s=7, mode 10: uo_out[7:2] runs 1,2,4,8,16,32,16,8,4,2,1,2.
REQ-032 Mode 11 from 0: after 64 ticks P wraps to 0; switch to mode 01 with P=000101 -> next tick P=000001.
REQ-033 ui_in[6]=1 or ena=0 for 20 cycles -> blink and P unchanged; release -> sequence resumes from held values; s changed 0->7 mid-count -> tick on next enabled edge.
